// File: rtl/dmem_arbiter_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
package dmem_arbiter_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;
endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, grant and read return.
interface dmem_arbiter_if;
  import dmem_arbiter_pkg::*;

  logic              req;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, write, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, write, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-owner pointer.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  owner_t last_q;

  // Reset to "B served last" so A wins the first contested round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= OWN_B;
    end else if (update) begin
      last_q <= grant[1] ? OWN_B : OWN_A;
    end
  end

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (last_q == OWN_A) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises port A / port B accesses onto the 16x8 data memory, one access per
// ACCESS cycle, with registered grant, memory drive and read-data return.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no access in flight; arbitrate on any request
//   ST_ACCESS | memory driven for the winner, winner's gnt high
//   ST_RESP   | read data returned (rvalid); re-arbitrate for next access
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  dmem_arbiter_if.slave     port_a,
  dmem_arbiter_if.slave     port_b,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
  logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

  logic [1:0] req_vec;
  logic [1:0] grant;
  logic       arb_update;

  assign req_vec = {port_b.req, port_a.req};

  rr_arbiter2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .req    (req_vec),
    .update (arb_update),
    .grant  (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_A;
      gnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rvalid_q  <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      rvalid_q  <= rvalid_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // Outputs are computed one state ahead so every pin comes straight off a flop.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    gnt_d      = '0;
    we_d       = 1'b0;
    addr_d     = addr_q;
    din_d      = din_q;
    rvalid_d   = '0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    arb_update = 1'b0;

    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (|req_vec) begin
          arb_update = 1'b1;
          state_d    = ST_ACCESS;
          gnt_d      = grant;
          if (grant[1]) begin
            owner_d = OWN_B;
            we_d    = port_b.write;
            addr_d  = port_b.addr;
            din_d   = port_b.wdata;
          end else begin
            owner_d = OWN_A;
            we_d    = port_a.write;
            addr_d  = port_a.addr;
            din_d   = port_a.wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        // Read address has been stable all cycle, so the combinational read is settled.
        if (!we_q) begin
          if (owner_q == OWN_B) begin
            rdata_b_d   = mem_data_out;
            rvalid_d[1] = 1'b1;
          end else begin
            rdata_a_d   = mem_data_out;
            rvalid_d[0] = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign port_a.gnt    = gnt_q[0];
  assign port_b.gnt    = gnt_q[1];
  assign port_a.rvalid = rvalid_q[0];
  assign port_b.rvalid = rvalid_q[1];
  assign port_a.rdata  = rdata_a_q;
  assign port_b.rdata  = rdata_b_q;

  assign mem_write_enable  = we_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_data_in       = din_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 16x8 data memory.
- Port A serves the core load/store path; port B serves the debug/loader path.
- Accepts one access at a time and drives the memory's write-enable, address and data inputs for exactly one cycle per access.
- Captures read data into a register and returns it with a valid pulse; round-robin fairness between A and B.

Parameters:
- ADDR_W, 4, memory address width (16 entries)
- DATA_W, 8, memory data width

Ports:
- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- A_Req  in  1  port A request; held until A_Gnt seen
- A_Write  in  1  1=write, 0=read; valid with A_Req
- A_Addr  in  ADDR_W  port A address
- A_Wdata  in  DATA_W  port A write data
- A_Gnt  out  1  one-cycle pulse: A's access is in progress
- A_Rvalid  out  1  one-cycle pulse: A_Rdata holds read result
- A_Rdata  out  DATA_W  port A read data
- B_Req, B_Write, B_Addr, B_Wdata, B_Gnt, B_Rvalid, B_Rdata: same as port A, for port B
- Mem_Write_Enable  out  1  to memory write enable
- Mem_Write_Address  out  ADDR_W  to memory write address
- Mem_Read_Address  out  ADDR_W  to memory read address
- Mem_Data_In  out  DATA_W  to memory write data
- Mem_Data_Out  in  DATA_W  from memory read data (combinational read)

Behaviour:
- Clocking and reset: one clock; Reset is asynchronous and active-high. While Reset is high, every output is 0, the FSM is in IDLE, and the round-robin pointer gives A priority.
- FSM states: IDLE, ACCESS, RESP. All state and outputs are registered.
- IDLE: if any Req is high at the clock edge, latch the winner's Write/Addr/Wdata and owner, then go to ACCESS. Otherwise stay in IDLE.
- ACCESS (exactly 1 cycle):
  - Winner's Gnt = 1.
  - Mem_Write_Address = Mem_Read_Address = latched address.
  - Mem_Data_In = latched data.
  - Mem_Write_Enable = latched Write.
  - Next state is always RESP.
- RESP (1 cycle):
  - Mem_Write_Enable = 0; addresses are held.
  - For a read, the owner's Rdata is loaded from Mem_Data_Out at the ACCESS->RESP edge, and the owner's Rvalid = 1 during RESP.
  - A write produces no Rvalid.
  - Arbitration is re-run at the end of RESP: go to ACCESS with a new winner if any Req is high, else go to IDLE.
- Latency and throughput: Req sampled at edge N -> Gnt during cycle N+1 -> Rvalid/Rdata during cycle N+2. Back-to-back throughput is one access per 2 cycles.
- Handshake:
  - A requester keeps Req, Write, Addr and Wdata stable until it samples Gnt=1.
  - It deasserts Req on the cycle after Gnt unless it has another access.
  - Rdata holds its value until the next read completes for that port.
- Round-robin: on simultaneous requests, grant the port not granted last. A lone request is always granted, and the pointer updates on every grant.
- Write enable is asserted for exactly one ACCESS cycle; it is never high in IDLE or RESP, or during Reset.
- Same-address write then read: the accesses are serialized, so the read returns the newly written value.
- Reset mid-operation: state and outputs clear immediately. A write in progress may be lost; a pending read produces no Rvalid.
- Address and data widths pass straight through; there is no address arithmetic.

Decomposition:
- Shared package holds:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2).
  - Owner encoding (OWN_A=0, OWN_B=1).
- One sub-module: rr_arbiter2. It takes two reqs and an update strobe, returns a one-hot grant, and holds the last-owner pointer.

Test Plan:
- Reset -> all outputs 0; release; A write addr 3 data 8'h5A -> A_Gnt pulses 1 cycle after request sample, with Mem_Write_Enable=1, Mem_Write_Address=3 and Mem_Data_In=8'h5A in that same cycle; no A_Rvalid.
- A read addr 3 after the write -> A_Rvalid pulses 2 cycles after request sample, with A_Rdata=8'h5A.
- A and B request simultaneously from reset (A writes addr 1=8'h11, B reads addr 1) -> A is granted first, B second; B_Rdata=8'h11.
- A and B both hold Req for 4 accesses -> grants alternate A,B,A,B; Gnt pulses spaced 2 cycles apart.
- B write addr 15=8'hFF, then B read addr 0 -> wrap of address space; read returns the prior content of addr 0, and addr 15 holds 8'hFF.
- Assert Reset during ACCESS of an A read -> Mem_Write_Enable and A_Gnt drop immediately; no A_Rvalid; FSM is IDLE after release.
